axi_lite_clint: RTL and testbench
=================================

# axi_lite_clint

AXI-lite responder implementing the core-local interruptor (CLINT) behind the core's MMIO AXI-lite master port. It holds the `msip`, `mtimecmp` and `mtime` registers, answers single-beat AXI-lite reads and writes to them, and drives the machine timer and software interrupt lines back to the core.

## Interface
- `ADDR_WIDTH`, 64: AXI address width.
- `DATA_WIDTH`, 64: AXI data width; only 64 is supported.
- `BASE_ADDR`, 64'h0200_0000: CLINT base; must be 64 KiB aligned.
- `TICK_DIV`, 1: clock cycles per `mtime` increment; must be ≥1.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `awaddr` in ADDR_WIDTH: write address.
- `awvalid` in 1 / `awready` out 1: write-address handshake.
- `wdata` in DATA_WIDTH: write data.
- `wstrb` in DATA_WIDTH/8: byte strobes.
- `wvalid` in 1 / `wready` out 1: write-data handshake.
- `bresp` out 2: write response.
- `bvalid` out 1 / `bready` in 1: write-response handshake.
- `araddr` in ADDR_WIDTH: read address.
- `arvalid` in 1 / `arready` out 1: read-address handshake.
- `rdata` out DATA_WIDTH: read data.
- `rresp` out 2: read response.
- `rvalid` out 1 / `rready` in 1: read-data handshake.
- `timer_irq` out 1: machine timer interrupt pending.
- `soft_irq` out 1: machine software interrupt pending.

## Operation
- Register map, as an offset from `BASE_ADDR`:
  - 0x0000 `msip`: only bit 0 is stored; other bits read 0.
  - 0x4000 `mtimecmp`: 64 bits.
  - 0xBFF8 `mtime`: 64 bits.
- Address decode:
  - Hit requires `addr[ADDR_WIDTH-1:16] == BASE_ADDR[ADDR_WIDTH-1:16]` and `addr[15:0]` equal to one of the three offsets.
  - `addr[2:0] != 0` → SLVERR (2'b10).
  - Any other miss → DECERR (2'b11).
  - On any error, writes have no effect and reads return `rdata = 0`.
  - OKAY is 2'b00.
- Writes merge bytewise: each register byte `i` takes `wdata[8i+7:8i]` only where `wstrb[i] = 1`.
- Write FSM:
  - States: `W_IDLE`, `W_RESP`.
  - In `W_IDLE`, `awready = wready = awvalid & wvalid`. AW and W are accepted only together in the same cycle; a lone `awvalid` or lone `wvalid` is left waiting.
  - On handshake: register update, latch `bresp`, go to `W_RESP`.
  - In `W_RESP`: `bvalid = 1`, `awready = wready = 0`. Return to `W_IDLE` on `bvalid & bready`.
- Read FSM:
  - States: `R_IDLE`, `R_DATA`.
  - In `R_IDLE`, `arready = 1`. On `arvalid`: latch `rdata`/`rresp` from the register values before that clock edge, go to `R_DATA`.
  - In `R_DATA`: `rvalid = 1`, `arready = 0`, `rdata`/`rresp` held stable. Return to `R_IDLE` on `rready`.
- The read and write FSMs are independent. When a read and a write to the same register handshake in the same cycle, the read returns the old value.
- Prescaler and `mtime`:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - `mtime` increments by 1 on each prescaler wrap; with TICK_DIV=1 that is every cycle.
  - `mtime` wraps from 2^64-1 to 0.
  - A write to `mtime` in the same cycle as an increment wins: the merged write value is stored, with no +1. A write to `mtime` does not reset the prescaler.
- Interrupt outputs:
  - `timer_irq = (mtime >= mtimecmp)`, unsigned, computed from the register outputs.
  - `soft_irq = msip[0]`.

## Timing
- Reset values:
  - `mtime = 0`, `mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF`, `msip = 0`, prescaler = 0.
  - Both FSMs in IDLE.
  - `bvalid = rvalid = 0`, `bresp = rresp = 0`, `rdata = 0`.
  - `timer_irq = soft_irq = 0`.
  - `arready = 1` (R_IDLE) and `awready = wready = 0` (no valids present).
- Reset mid-transaction aborts it. Any pending B or R beat is dropped and registers return to reset values.
- Write latency:
  - `bvalid` rises in the cycle after the AW/W handshake.
  - Registers and interrupt outputs reflect the write in that same cycle.
  - Minimum 2 cycles per write; the next write can be accepted the cycle after B completes.
- Read latency:
  - `rvalid` rises in the cycle after the AR handshake.
  - Minimum 2 cycles per read; the next AR can be accepted the cycle after R completes.
- Backpressure on `bready`/`rready` may last arbitrarily long. The outputs stay stable and `mtime` keeps counting meanwhile.
- `timer_irq` tracks `mtime` every cycle with no extra register stage.

## Test plan
- Reset, TICK_DIV=1, no traffic for 10 cycles → read 0xBFF8 returns a value of 10±2 with OKAY; `timer_irq = 0`, `soft_irq = 0`.
- Write `mtimecmp = 100` with `wstrb = 0xFF` while `mtime = 50` → `timer_irq` rises on the cycle `mtime` reaches 100. Then write `mtimecmp = 0xFFFF_FFFF_FFFF_FFFF` → `timer_irq = 0` in the cycle after the handshake.
- Write `msip = 0xFFFF_FFFF_FFFF_FFFF` → reads back 1 and `soft_irq = 1`. Then write 0 with `wstrb = 0x00` → `msip` stays 1.
- Write `mtime = 0xFFFF_FFFF_FFFF_FFFE` → two cycles later `mtime` reads 0 (wrap). Write `0x1122` with `wstrb = 0x01` onto `mtime = 0xAB00` in a cycle with an increment → `mtime = 0xAB22`.
- Read `BASE + 0x0004` → SLVERR with `rdata = 0`. Write `BASE + 0x1000` → DECERR with no register change. Read `0x0300_0000` → DECERR.
- Present AW without W for 5 cycles → `awready = 0` throughout. Then a W arrives → same-cycle handshake. Hold `bready = 0` for 8 cycles → `bvalid` and `bresp` stable, then completes. A concurrent read of `mtimecmp` proceeds independently.

Source files
------------

// File: rtl/axi_lite_clint.sv
// axi_lite_clint
//   Core-local interruptor behind an AXI-lite responder. Holds msip,
//   mtimecmp and mtime, answers single-beat reads/writes to them and drives
//   the machine timer / software interrupt lines.
//
//   Register map (offset from BASE_ADDR):
//     0x0000 msip     (bit 0 only)
//     0x4000 mtimecmp (64 bit)
//     0xBFF8 mtime    (64 bit, +1 every TICK_DIV cycles)
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   aw*/w*/b*                   AXI-lite write address/data/response
//   ar*/r*                      AXI-lite read address/data
//   timer_irq                   mtime >= mtimecmp (unsigned)
//   soft_irq                    msip[0]
module axi_lite_clint #(
    parameter int unsigned              ADDR_WIDTH = 64,
    parameter int unsigned              DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 64'h0200_0000,
    parameter int unsigned              TICK_DIV   = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    timer_irq,
    output logic                    soft_irq
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} sel_e;
    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    function automatic sel_e decode_sel(input logic [ADDR_WIDTH-1:0] a);
        if (a[ADDR_WIDTH-1:16] != BASE_ADDR[ADDR_WIDTH-1:16]) return SEL_NONE;
        case (a[15:0])
            OFF_MSIP:     return SEL_MSIP;
            OFF_MTIMECMP: return SEL_MTIMECMP;
            OFF_MTIME:    return SEL_MTIME;
            default:      return SEL_NONE;
        endcase
    endfunction

    // Misalignment is reported as SLVERR anywhere, ahead of decode misses.
    function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] a,
                                               input sel_e s);
        if (a[2:0] != 3'b000) return RESP_SLVERR;
        if (s == SEL_NONE)    return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] data,
                                                    input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] m;
        m = old;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (strb[i]) m[8*i +: 8] = data[8*i +: 8];
        end
        return m;
    endfunction

    wstate_e                wstate_q, wstate_d;
    rstate_e                rstate_q, rstate_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]  mtime_q, mtime_d;
    logic [DATA_WIDTH-1:0]  mtimecmp_q, mtimecmp_d;
    logic                   msip_q, msip_d;
    logic [PW-1:0]          presc_q, presc_d;

    sel_e                   wsel, rsel;
    logic [1:0]             wresp_dec, rresp_dec;
    logic                   whs;
    logic                   tick;
    logic [DATA_WIDTH-1:0]  rd_val;

    always_comb begin
        wsel      = decode_sel(awaddr);
        rsel      = decode_sel(araddr);
        wresp_dec = decode_resp(awaddr, wsel);
        rresp_dec = decode_resp(araddr, rsel);
    end

    // Write channel: AW and W are only taken together.
    always_comb begin
        wstate_d = wstate_q;
        bresp_d  = bresp_q;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        whs      = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready = awvalid & wvalid;
                wready  = awvalid & wvalid;
                if (awvalid && wvalid) begin
                    whs      = 1'b1;
                    bresp_d  = wresp_dec;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wstate_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (rsel)
            SEL_MSIP:     rd_val[0] = msip_q;
            SEL_MTIMECMP: rd_val    = mtimecmp_q;
            SEL_MTIME:    rd_val    = mtime_q;
            default:      rd_val    = '0;
        endcase
    end

    // Read channel: data is captured from register state before the edge,
    // so a same-cycle write to the same register is not visible.
    always_comb begin
        rstate_d = rstate_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        arready  = 1'b0;
        rvalid   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    rresp_d  = rresp_dec;
                    rdata_d  = (rresp_dec == RESP_OKAY) ? rd_val : '0;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) rstate_d = R_IDLE;
            end
        endcase
    end

    // Timebase and register updates; a write to mtime overrides the tick.
    always_comb begin
        tick       = (presc_q == PW'(TICK_DIV - 1));
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_d    = tick ? mtime_q + DATA_WIDTH'(1) : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (whs && (wresp_dec == RESP_OKAY)) begin
            case (wsel)
                SEL_MSIP:     if (wstrb[0]) msip_d = wdata[0];
                SEL_MTIMECMP: mtimecmp_d = merge(mtimecmp_q, wdata, wstrb);
                SEL_MTIME:    mtime_d    = merge(mtime_q, wdata, wstrb);
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            bresp_q    <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            presc_q    <= '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            presc_q    <= presc_d;
        end
    end

    assign bresp     = bresp_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign timer_irq = (mtime_q >= mtimecmp_q);
    assign soft_irq  = msip_q;

endmodule

// File: tb/tb_axi_lite_clint.sv
// tb_axi_lite_clint
//   Directed stimulus against axi_lite_clint with a transaction-level model
//   of the CLINT register file that is compared against the DUT every cycle,
//   plus hand-computed literal expectations.
module tb_axi_lite_clint;

    localparam logic [63:0] BASE = 64'h0200_0000;
    localparam int          TDIV = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [7:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    logic        timer_irq, soft_irq;

    int checks = 0;
    int errors = 0;

    axi_lite_clint #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .BASE_ADDR (64'h0200_0000),
        .TICK_DIV  (TDIV)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .timer_irq(timer_irq),
        .soft_irq (soft_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake, expected one within 20 cycles (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime, m_cmp, m_next, m_rdata;
    logic        m_msip, m_w_busy, m_r_busy, mw_do;
    logic [1:0]  m_bresp, m_rresp;
    int          m_pre;

    function automatic logic [1:0] m_resp(input logic [63:0] a);
        logic [63:0] off;
        if (a % 8 != 0) return 2'b10;
        if (a < BASE || a >= BASE + 64'h1_0000) return 2'b11;
        off = a - BASE;
        if (off == 64'h0 || off == 64'h4000 || off == 64'hBFF8) return 2'b00;
        return 2'b11;
    endfunction

    function automatic logic [63:0] m_merge(input logic [63:0] old, input logic [63:0] d,
                                            input logic [7:0] s);
        logic [63:0] mask;
        mask = 64'h0;
        for (int i = 0; i < 8; i++) if (s[i]) mask = mask | (64'hFF << (8 * i));
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [63:0] m_reg(input logic [63:0] a);
        if (a == BASE) return {63'h0, m_msip};
        if (a == BASE + 64'h4000) return m_cmp;
        return m_mtime;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_mtime  = 64'h0;
                m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip   = 1'b0;
                m_pre    = 0;
                m_w_busy = 1'b0;
                m_r_busy = 1'b0;
                m_bresp  = 2'b00;
                m_rresp  = 2'b00;
                m_rdata  = 64'h0;
            end else begin
                if (m_r_busy) begin
                    if (rready) m_r_busy = 1'b0;
                end else if (arvalid) begin
                    m_r_busy = 1'b1;
                    m_rresp  = m_resp(araddr);
                    m_rdata  = (m_rresp == 2'b00) ? m_reg(araddr) : 64'h0;
                end
                mw_do = 1'b0;
                if (m_w_busy) begin
                    if (bready) m_w_busy = 1'b0;
                end else if (awvalid && wvalid) begin
                    mw_do    = 1'b1;
                    m_w_busy = 1'b1;
                    m_bresp  = m_resp(awaddr);
                end
                m_pre = m_pre + 1;
                if (m_pre == TDIV) begin
                    m_pre  = 0;
                    m_next = m_mtime + 64'd1;
                end else begin
                    m_next = m_mtime;
                end
                if (mw_do && m_bresp == 2'b00) begin
                    if (awaddr == BASE) begin
                        if (wstrb[0]) m_msip = wdata[0];
                    end else if (awaddr == BASE + 64'h4000) begin
                        m_cmp = m_merge(m_cmp, wdata, wstrb);
                    end else begin
                        m_next = m_merge(m_mtime, wdata, wstrb);
                    end
                end
                m_mtime = m_next;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rstn) begin
                chk("bvalid", bvalid, m_w_busy);
                chk("rvalid", rvalid, m_r_busy);
                chk("arready", arready, !m_r_busy);
                chk("awready", awready, !m_w_busy && awvalid && wvalid);
                chk("wready", wready, !m_w_busy && awvalid && wvalid);
                chk("timer_irq", timer_irq, m_mtime >= m_cmp);
                chk("soft_irq", soft_irq, m_msip);
                if (m_w_busy) chk("bresp", bresp, m_bresp);
                if (m_r_busy) begin
                    chk("rresp", rresp, m_rresp);
                    chk("rdata", rdata, m_rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- bus tasks (start on a falling edge) ----------------
    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        if (!awready) timeout_fail("aw_handshake");
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
        if (!bvalid) timeout_fail("b_beat");
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        if (!arready) timeout_fail("ar_handshake");
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
        if (!rvalid) timeout_fail("r_beat");
        d = rdata; resp = rresp;
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    logic [63:0] d, d2;
    logic [1:0]  r, r2, b0;
    int          n;

    initial begin
        rstn = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_arready", arready, 1'b1);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_timer_irq", timer_irq, 1'b0);
        chk("rst_soft_irq", soft_irq, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        // free-running mtime after 10 idle cycles
        repeat (10) @(negedge clk);
        axi_read(BASE + 64'hBFF8, d, r);
        chk("mtime_10_range", (d >= 64'd8 && d <= 64'd12), 1'b1);
        chk("mtime_10_resp", r, 2'b00);
        chk("idle_timer_irq", timer_irq, 1'b0);

        // timer compare: mtime=40, mtimecmp=100 -> 43 at return, rises 57 cycles later
        axi_write(BASE + 64'hBFF8, 64'd40, 8'hFF, r);
        chk("wr_mtime_resp", r, 2'b00);
        axi_write(BASE + 64'h4000, 64'd100, 8'hFF, r);
        chk("timer_irq_before", timer_irq, 1'b0);
        n = 0;
        while (!timer_irq && n < 200) begin @(negedge clk); n++; end
        chk("timer_rise_cycles", n, 57);
        axi_write(BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
        chk("timer_irq_cleared", timer_irq, 1'b0);

        // msip: only bit 0 stored, zero strobes leave it unchanged
        axi_write(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
        chk("soft_irq_set", soft_irq, 1'b1);
        axi_read(BASE, d, r);
        chk("msip_readback", d, 64'h1);
        axi_write(BASE, 64'h0, 8'h00, r);
        axi_read(BASE, d, r);
        chk("msip_strb0", d, 64'h1);

        // mtime wrap: FE stored, read issued one cycle late latches 0
        axi_write(BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, r);
        @(negedge clk);
        axi_read(BASE + 64'hBFF8, d, r);
        chk("mtime_wrap", d, 64'h0);

        // byte merge against a ticking mtime: AB00 -> AB01 at merge -> AB22, read sees AB23
        axi_write(BASE + 64'hBFF8, 64'hAB00, 8'hFF, r);
        axi_write(BASE + 64'hBFF8, 64'h1122, 8'h01, r);
        axi_read(BASE + 64'hBFF8, d, r);
        chk("mtime_merge", d, 64'hAB23);

        // decode errors
        axi_read(BASE + 64'h4, d, r);
        chk("slverr_resp", r, 2'b10);
        chk("slverr_data", d, 64'h0);
        axi_write(BASE + 64'h1000, 64'h55, 8'hFF, r);
        chk("decerr_wr_resp", r, 2'b11);
        axi_read(BASE + 64'h4000, d, r);
        chk("decerr_no_effect", d, 64'hFFFF_FFFF_FFFF_FFFF);
        axi_read(64'h0300_0000, d, r);
        chk("decerr_rd_resp", r, 2'b11);
        chk("decerr_rd_data", d, 64'h0);

        // same-cycle read and write of msip: read returns the old value
        fork
            axi_write(BASE, 64'h0, 8'hFF, r2);
            axi_read(BASE, d, r);
        join
        chk("rw_same_cycle_old", d, 64'h1);
        chk("rw_same_cycle_soft", soft_irq, 1'b0);

        // lone AW, then W; B backpressure with a concurrent read
        @(negedge clk);
        awaddr = BASE; wdata = 64'h1; wstrb = 8'h01; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lone_aw_awready", awready, 1'b0);
            chk("lone_aw_wready", wready, 1'b0);
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1;
        chk("aw_w_same_cycle", awready, 1'b1);
        fork
            begin
                @(negedge clk);
                awvalid = 1'b0; wvalid = 1'b0;
                #1;
                chk("bp_bvalid_first", bvalid, 1'b1);
                b0 = bresp;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_bvalid_held", bvalid, 1'b1);
                    chk("bp_bresp_stable", bresp, b0);
                    chk("bp_bresp_okay", bresp, 2'b00);
                end
                bready = 1'b1;
                @(negedge clk);
                #1;
                chk("bp_bvalid_done", bvalid, 1'b0);
            end
            begin
                @(negedge clk);
                axi_read(BASE + 64'h4000, d2, r);
                chk("concurrent_rd_data", d2, 64'hFFFF_FFFF_FFFF_FFFF);
                chk("concurrent_rd_resp", r, 2'b00);
            end
        join
        chk("bp_soft_irq", soft_irq, 1'b1);

        // reset in the middle of pending B and R beats
        @(negedge clk);
        awaddr = BASE + 64'h4000; wdata = 64'd5; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        araddr = BASE + 64'hBFF8; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        #1;
        chk("pre_rst_bvalid", bvalid, 1'b1);
        chk("pre_rst_rvalid", rvalid, 1'b1);
        chk("pre_rst_timer_irq", timer_irq, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_rdata", rdata, 64'h0);
        chk("mid_rst_timer_irq", timer_irq, 1'b0);
        chk("mid_rst_soft_irq", soft_irq, 1'b0);
        chk("mid_rst_arready", arready, 1'b1);
        @(negedge clk);
        rstn = 1'b1; bready = 1'b1; rready = 1'b1;
        axi_read(BASE + 64'h4000, d, r);
        chk("post_rst_mtimecmp", d, 64'hFFFF_FFFF_FFFF_FFFF);
        axi_read(BASE, d, r);
        chk("post_rst_msip", d, 64'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
